// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4-to-1 mux between four requesters; drives s1/s0 and a one-hot grant.
// Optional owner hold limit is enabled by defining ARB_HOLD_LIMIT_EN.
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] owner, owner_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [3:0] gnt_nxt;
    logic [3:0] owner_hot;
    logic [3:0] others;
    logic [2:0] pick_any;
    logic [2:0] pick_other;
    logic       preempt;

    if (HOLD_MAX < 1 || HOLD_MAX > (2**CNT_W) - 1) begin : g_bad_hold_max
        $error("mux4_rr_arbiter: HOLD_MAX outside 1..2**CNT_W-1");
    end

    // First set bit of mask searching start, start+1, ... (mod 4); bit 2 flags a valid result.
    function automatic logic [2:0] pick(input logic [3:0] mask, input logic [1:0] start);
        logic [2:0] result;
        logic [1:0] idx;
        result = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (mask[idx]) result = {1'b1, idx};
        end
        return result;
    endfunction

    assign owner_hot  = 4'b0001 << owner;
    assign others     = req & ~owner_hot;
    assign pick_any   = pick(req, ptr);
    assign pick_other = pick(others, ptr);

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             new_grant;

    assign preempt   = (state == OWN) && (hold_cnt >= HOLD_LIM) && (others != 4'b0000);
    assign new_grant = (state_nxt == OWN) && ((state == IDLE) || (owner_nxt != owner));

    // Counter restarts on every new owner and when the limit is hit with nobody waiting; saturates otherwise.
    always_comb begin
        hold_cnt_nxt = hold_cnt;
        if (new_grant) begin
            hold_cnt_nxt = CNT_W'(1);
        end else if (state_nxt == OWN) begin
            if (hold_cnt >= HOLD_LIM)
                hold_cnt_nxt = CNT_W'(1);
            else if (hold_cnt != {CNT_W{1'b1}})
                hold_cnt_nxt = hold_cnt + 1'b1;
        end else begin
            hold_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= '0;
        else
            hold_cnt <= hold_cnt_nxt;
    end
`else
    assign preempt = 1'b0;
`endif

    // A releasing or pre-empted owner hands over on the same edge, so there is no idle bubble.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt;
        case (state)
            IDLE: begin
                gnt_nxt = 4'b0000;
                if (pick_any[2]) begin
                    state_nxt = OWN;
                    owner_nxt = pick_any[1:0];
                    ptr_nxt   = pick_any[1:0] + 2'd1;
                    gnt_nxt   = 4'b0001 << pick_any[1:0];
                end
            end
            OWN: begin
                if (req[owner] && !preempt) begin
                    state_nxt = OWN;
                end else if (pick_other[2]) begin
                    owner_nxt = pick_other[1:0];
                    ptr_nxt   = pick_other[1:0] + 2'd1;
                    gnt_nxt   = 4'b0001 << pick_other[1:0];
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 2'b00;
            ptr   <= 2'b00;
            gnt   <= 4'b0000;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
            gnt   <= gnt_nxt;
        end
    end

    assign s1   = owner[1];
    assign s0   = owner[0];
    assign busy = |gnt;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus randomized traffic
// against a behavioural round-robin model (honours ARB_HOLD_LIMIT_EN when defined).
module tb_mux4_rr_arbiter;

    localparam int HOLD_MAX = 4;
    localparam int CNT_W    = 4;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       s1, s0, busy;

    int checks = 0;
    int passed = 0;

    int m_ptr   = 0;
    int m_owner = 0;
    int m_cnt   = 0;
    bit m_busy  = 1'b0;

    mux4_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .gnt  (gnt),
        .s1   (s1),
        .s0   (s0),
        .busy (busy)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] mask, input int start);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (start + k) % 4;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [6:0] model_vec();
        logic [3:0] g;
        g = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        return {g, 2'(m_owner), m_busy};
    endfunction

    // Reference model: one arbitration decision per rising edge from the sampled requests.
    always @(posedge clk or negedge rst_n) begin : model
        logic [3:0] oth;
        int         w;
        if (!rst_n) begin
            m_ptr = 0; m_owner = 0; m_cnt = 0; m_busy = 1'b0;
        end else begin
            oth = req;
            oth[m_owner] = 1'b0;
            w = -1;
            if (!m_busy) begin
                if (req != 4'b0000) w = pick(req, m_ptr);
            end else if (req[m_owner] && !(HOLD_EN && m_cnt >= HOLD_MAX && oth != 4'b0000)) begin
                if (HOLD_EN) m_cnt = (m_cnt >= HOLD_MAX) ? 1 : m_cnt + 1;
            end else if (oth != 4'b0000) begin
                w = pick(oth, m_ptr);
            end else begin
                m_busy = 1'b0;
                m_cnt  = 0;
            end
            if (w >= 0) begin
                m_owner = w;
                m_ptr   = (w + 1) % 4;
                m_busy  = 1'b1;
                m_cnt   = 1;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        checks++;
        if ({gnt, s1, s0, busy} !== 7'b0000_00_0)
            $display("[TB] FAIL reset_initial: got gnt=%b s=%b%b busy=%b, expected all zero", gnt, s1, s0, busy);
        else passed++;
        req = 4'b1111;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, s1, s0, busy} !== 7'b0000_00_0)
            $display("[TB] FAIL reset_held: got gnt=%b s=%b%b busy=%b, expected all zero", gnt, s1, s0, busy);
        else passed++;
        req   = 4'b0000;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({gnt, s1, s0, busy} !== 7'b0100_10_1)
                $display("[TB] FAIL basic_grant: got gnt=%b s=%b%b busy=%b, expected 0100/10/1", gnt, s1, s0, busy);
            else passed++;
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if ({gnt, s1, s0, busy} !== 7'b0000_10_0)
            $display("[TB] FAIL basic_release: got gnt=%b s=%b%b busy=%b, expected 0000/10/0", gnt, s1, s0, busy);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int held;
        int prev;
        int seq[$];
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        logic [3:0] r;
        do_reset();
        req  = 4'b1111;
        held = 0;
        prev = -1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            checks++;
            if ({gnt, s1, s0, busy} !== model_vec())
                $display("[TB] FAIL b2b_model: cycle %0d got %b expected %b", c, {gnt, s1, s0, busy}, model_vec());
            else passed++;
            checks++;
            if (busy !== 1'b1)
                $display("[TB] FAIL b2b_no_bubble: cycle %0d busy=%b, expected 1", c, busy);
            else passed++;
            if (busy === 1'b1 && (seq.size() == 0 || seq[$] != int'({s1, s0})))
                seq.push_back(int'({s1, s0}));
            held = (m_owner == prev) ? held + 1 : 1;
            prev = m_owner;
            r = 4'b1111;
            if (held == 2) r[m_owner] = 1'b0;
            req = r;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= seq.size())
                $display("[TB] FAIL b2b_order: grant %0d missing, expected owner %0d", i, exp_seq[i]);
            else if (seq[i] != exp_seq[i])
                $display("[TB] FAIL b2b_order: grant %0d got owner %0d expected %0d", i, seq[i], exp_seq[i]);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b1000;
        @(negedge clk);
        checks++;
        if ({gnt, s1, s0} !== 6'b1000_11)
            $display("[TB] FAIL wrap_owner3: got gnt=%b s=%b%b, expected 1000/11", gnt, s1, s0);
        else passed++;
        req = 4'b1001;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b1000)
            $display("[TB] FAIL wrap_hold: got gnt=%b, expected 1000", gnt);
        else passed++;
        req = 4'b0001;
        @(negedge clk);
        checks++;
        if ({gnt, s1, s0, busy} !== 7'b0001_00_1)
            $display("[TB] FAIL wrap_to0: got gnt=%b s=%b%b busy=%b, expected 0001/00/1", gnt, s1, s0, busy);
        else passed++;
        do_reset();
        req = 4'b1000;
        @(negedge clk);
        req = 4'b0110;
        @(negedge clk);
        checks++;
        if ({gnt, s1, s0} !== 6'b0010_01)
            $display("[TB] FAIL wrap_ptr0_search: got gnt=%b s=%b%b, expected 0010/01", gnt, s1, s0);
        else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010)
            $display("[TB] FAIL areset_pre: got gnt=%b, expected 0010", gnt);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, s1, s0, busy} !== 7'b0000_00_0)
            $display("[TB] FAIL areset_immediate: got gnt=%b s=%b%b busy=%b, expected all zero", gnt, s1, s0, busy);
        else passed++;
        @(negedge clk);
        req   = 4'b1010;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt, s1, s0, busy} !== 7'b0010_01_1)
            $display("[TB] FAIL areset_after: got gnt=%b s=%b%b busy=%b, expected 0010/01/1", gnt, s1, s0, busy);
        else passed++;
    endtask

    task automatic test_hold_limit();
        logic [3:0] exp;
        do_reset();
        req = 4'b0011;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (HOLD_EN) exp = (((k - 1) / HOLD_MAX) % 2 == 0) ? 4'b0001 : 4'b0010;
            else exp = 4'b0001;
            checks++;
            if (gnt !== exp)
                $display("[TB] FAIL hold_alternate: cycle %0d got gnt=%b expected %b", k, gnt, exp);
            else passed++;
        end
        req = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0001)
                $display("[TB] FAIL hold_single: cycle %0d got gnt=%b expected 0001", k, gnt);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        do_reset();
        r = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 5))
                0, 1:    r = 4'($urandom_range(0, 15));
                2:       if (m_busy) r[m_owner] = 1'b0;
                default: ;
            endcase
            req = r;
            @(negedge clk);
            checks++;
            if ({gnt, s1, s0, busy} !== model_vec())
                $display("[TB] FAIL random_model: cycle %0d req=%b got %b expected %b", c, req, {gnt, s1, s0, busy}, model_vec());
            else passed++;
            checks++;
            if (!$onehot0(gnt) || busy !== (|gnt))
                $display("[TB] FAIL random_invariant: cycle %0d gnt=%b busy=%b", c, gnt, busy);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_hold_limit();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-1 multiplexer between four requesters.
- Drives the mux select lines s1/s0 and a one-hot grant vector, so exactly one requester owns the mux datapath at a time.
- Sits directly in front of the mux4to1 datapath.
- Registered grant; no idle bubble between back-to-back owners.

Parameters:
HOLD_MAX, 8, max consecutive grant cycles per owner while others wait (used only with ARB_HOLD_LIMIT_EN); legal range 1..(2**CNT_W - 1)
CNT_W, 4, width of the hold counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  request per requester; req[i] held high while requester i wants the mux
gnt  output  4  one-hot registered grant; all zero when idle
s1  output  1  mux select MSB = index of current/last owner, bit 1
s0  output  1  mux select LSB = index of current/last owner, bit 0
busy  output  1  high when any gnt bit is high

Behaviour:
- Reset (rst_n low, asynchronous, also mid-grant):
  - gnt=4'b0000, {s1,s0}=2'b00, busy=0.
  - Priority pointer ptr=0, hold counter=0, state IDLE.
  - Outputs clear immediately, not at the next edge.
- States: IDLE (no owner), OWN (gnt[owner]=1).
- Winner selection: first i with req[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE:
  - If req!=0 at a rising edge: winner registered on that edge; gnt/{s1,s0}/busy update 1 cycle after req is sampled; go OWN.
  - ptr <= winner+1 (mod 4, 2-bit wrap: 3 -> 0).
- OWN:
  - req[owner]=1: keep grant, outputs unchanged.
  - req[owner]=0 and another req bit set: new winner registered at the same edge; no zero-grant cycle between owners. Search starts at ptr, which already points past the old owner. Update ptr.
  - req[owner]=0 and req=0: go IDLE; gnt=0, busy=0.
- {s1,s0} always equals the binary index of the set gnt bit. When idle, {s1,s0} holds the last owner's index.
- gnt is never multi-hot. A grant is never issued to a requester whose req was low at the deciding edge.
- Simultaneous requests: pointer order decides. After reset, req=4'b1111 grants order 0,1,2,3,0...
- A requester dropping and re-raising req while not owner gains no priority; only ptr decides.
- Owner dropping req and re-raising it in the same cycle another request arrives: arbitration uses the sampled values only.

Optional Feature:
ARB_HOLD_LIMIT_EN
- Defined:
  - Hold counter counts consecutive OWN cycles of the current owner. It resets to 1 on each new grant.
  - When counter reaches HOLD_MAX and any other req bit is set, the owner is pre-empted at the next edge even though req[owner]=1. The next winner follows normal pointer search, excluding the owner.
  - If no other request is pending at HOLD_MAX, the owner keeps the grant and the counter restarts at 1.
  - Counter saturates; it never wraps into a false pre-emption.
- Undefined:
  - No counter logic; an owner keeps the grant indefinitely while req[owner]=1.
  - HOLD_MAX and CNT_W are unused.

Test Plan:
1. Reset then req=4'b0100 at cycle 2 -> gnt=4'b0100, {s1,s0}=10, busy=1 from cycle 3. req=0 at cycle 6 -> gnt=0, busy=0 at cycle 7, {s1,s0} stays 10.
2. req=4'b1111 held; each owner drops req for 1 cycle after 2 cycles of grant, then re-raises -> grant order 0,1,2,3,0 with no zero-grant cycle between owners.
3. Owner 3 active, ptr wraps: req=4'b1001, owner 3 releases -> gnt=4'b0001, {s1,s0}=00 the next cycle (3 -> 0 wrap).
4. rst_n pulled low mid-grant (gnt=4'b0010) between clock edges -> gnt=0, {s1,s0}=00, busy=0 immediately. After release with req=4'b1010 -> gnt=4'b0010 first (ptr=0 search).
5. ARB_HOLD_LIMIT_EN, HOLD_MAX=4: req=4'b0011 held continuously -> gnt alternates 4'b0001 for 4 cycles, 4'b0010 for 4 cycles, repeating. Only req=4'b0001 held -> gnt=4'b0001 indefinitely.
6. Without ARB_HOLD_LIMIT_EN, same stimulus as 5 -> gnt=4'b0001 for the whole run.
